// File: rtl/agg_collect_pkg.sv
// Shared definitions for the aggregation collector: memory map, flag bit
// positions, datapath widths and small word helpers.
package agg_collect_pkg;

    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 11;
    localparam int ACC_W   = 20;
    localparam int COUNT_W = 5;

    // Default memory map of the member record
    localparam logic [ADDR_W-1:0] FLAGS_ADDR_DEF = 11'h001;
    localparam logic [ADDR_W-1:0] COUNT_ADDR_DEF = 11'h002;
    localparam logic [ADDR_W-1:0] SUM_ADDR_DEF   = 11'h004;
    localparam logic [ADDR_W-1:0] MAX_ADDR_DEF   = 11'h005;
    localparam logic [ADDR_W-1:0] BUF_BASE_DEF   = 11'h010;

    // Bit positions inside the flags word
    localparam int FLAG_ROLE_BIT = 7;
    localparam int FLAG_AGG_BIT  = 6;

    // Clamp the wide accumulator to a single memory word
    function automatic logic [WORD_W-1:0] sat_word(input logic [ACC_W-1:0] v);
        return (|v[ACC_W-1:WORD_W]) ? {WORD_W{1'b1}} : v[WORD_W-1:0];
    endfunction

    // Consume the aggregation request; the role bit and every other bit pass through
    function automatic logic [WORD_W-1:0] clear_agg_flag(input logic [WORD_W-1:0] f);
        logic [WORD_W-1:0] r;
        r                = f;
        r[FLAG_AGG_BIT]  = 1'b0;
        r[FLAG_ROLE_BIT] = f[FLAG_ROLE_BIT];
        return r;
    endfunction

endpackage

// File: rtl/agg_collect.sv
// Aggregation collector: reads a flags word and a member count from memory,
// sums and maxes the member words, then writes sum, max and the updated flags.
// All memory-side outputs are registered; reads use a two-cycle ADDR/CAP rhythm.
module agg_collect
    import agg_collect_pkg::*;
#(
    parameter int                MAX_MEMBERS = 16,
    parameter logic [ADDR_W-1:0] FLAGS_ADDR  = FLAGS_ADDR_DEF,
    parameter logic [ADDR_W-1:0] COUNT_ADDR  = COUNT_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SUM_ADDR    = SUM_ADDR_DEF,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = MAX_ADDR_DEF,
    parameter logic [ADDR_W-1:0] BUF_BASE    = BUF_BASE_DEF
) (
    input  logic              clock,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    output logic [ADDR_W-1:0] address,
    output logic              wr_en,
    output logic [WORD_W-1:0] data_out,
    output logic              aggregated,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_FLAGS,
        S_RD_COUNT,
        S_RD_DATA,
        S_WR_SUM,
        S_WR_MAX,
        S_WR_FLAGS,
        S_DONE
    } state_e;

    localparam logic [COUNT_W-1:0] MAX_N = COUNT_W'(MAX_MEMBERS);

    state_e              state_q,      state_d;
    logic                cap_q,        cap_d;      // 0: address phase, 1: capture phase
    logic [ADDR_W-1:0]   address_q,    address_d;
    logic                wr_en_q,      wr_en_d;
    logic [WORD_W-1:0]   data_out_q,   data_out_d;
    logic                aggregated_q, aggregated_d;
    logic                done_q,       done_d;
    logic [WORD_W-1:0]   flags_q,      flags_d;
    logic [COUNT_W-1:0]  count_q,      count_d;
    logic [COUNT_W-1:0]  idx_q,        idx_d;
    logic [ACC_W-1:0]    sum_q,        sum_d;
    logic [WORD_W-1:0]   max_q,        max_d;

    logic [ACC_W-1:0]    sum_acc;
    logic [WORD_W-1:0]   max_acc;
    logic [COUNT_W-1:0]  n_raw;
    logic [COUNT_W-1:0]  n_clamp;

    assign sum_acc = sum_q + ACC_W'(data_in);
    assign max_acc = (data_in > max_q) ? data_in : max_q;
    assign n_raw   = data_in[COUNT_W-1:0];
    assign n_clamp = (n_raw > MAX_N) ? MAX_N : n_raw;

    // State and output registers, cleared immediately by nrst
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            cap_q        <= 1'b0;
            address_q    <= '0;
            wr_en_q      <= 1'b0;
            data_out_q   <= '0;
            aggregated_q <= 1'b0;
            done_q       <= 1'b0;
            flags_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            max_q        <= '0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            address_q    <= address_d;
            wr_en_q      <= wr_en_d;
            data_out_q   <= data_out_d;
            aggregated_q <= aggregated_d;
            done_q       <= done_d;
            flags_q      <= flags_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            max_q        <= max_d;
        end
    end

    // Next-state and next-output logic; write strobe and data default low
    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        address_d    = address_q;
        wr_en_d      = 1'b0;
        data_out_d   = '0;
        aggregated_d = aggregated_q;
        done_d       = done_q;
        flags_d      = flags_q;
        count_d      = count_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        max_d        = max_q;

        case (state_q)
            S_IDLE: begin
                if (en && start) begin
                    address_d = FLAGS_ADDR;
                    cap_d     = 1'b0;
                    flags_d   = '0;
                    count_d   = '0;
                    idx_d     = '0;
                    sum_d     = '0;
                    max_d     = '0;
                    state_d   = S_RD_FLAGS;
                end
            end

            S_RD_FLAGS: begin
                if (!cap_q) begin
                    cap_d = 1'b1;
                end else begin
                    cap_d   = 1'b0;
                    flags_d = data_in;
                    if (!data_in[FLAG_AGG_BIT]) begin
                        aggregated_d = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        address_d = COUNT_ADDR;
                        state_d   = S_RD_COUNT;
                    end
                end
            end

            S_RD_COUNT: begin
                if (!cap_q) begin
                    cap_d = 1'b1;
                end else begin
                    cap_d   = 1'b0;
                    count_d = n_clamp;
                    if (n_clamp == '0) begin
                        // Empty member list: go straight to the result writes
                        address_d  = SUM_ADDR;
                        data_out_d = sat_word(sum_q);
                        wr_en_d    = 1'b1;
                        state_d    = S_WR_SUM;
                    end else begin
                        address_d = BUF_BASE;
                        state_d   = S_RD_DATA;
                    end
                end
            end

            S_RD_DATA: begin
                if (!cap_q) begin
                    cap_d = 1'b1;
                end else begin
                    cap_d = 1'b0;
                    sum_d = sum_acc;
                    max_d = max_acc;
                    if (idx_q == count_q - 1'b1) begin
                        // Last member: the sum write goes out with the fresh total
                        address_d  = SUM_ADDR;
                        data_out_d = sat_word(sum_acc);
                        wr_en_d    = 1'b1;
                        state_d    = S_WR_SUM;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        address_d = address_q + 1'b1;
                    end
                end
            end

            // The three result writes go out on successive cycles, each its own
            // single-cycle strobe carrying its own address and data.
            S_WR_SUM: begin
                address_d  = MAX_ADDR;
                data_out_d = max_q;
                wr_en_d    = 1'b1;
                state_d    = S_WR_MAX;
            end

            S_WR_MAX: begin
                address_d  = FLAGS_ADDR;
                data_out_d = clear_agg_flag(flags_q);
                wr_en_d    = 1'b1;
                state_d    = S_WR_FLAGS;
            end

            S_WR_FLAGS: begin
                aggregated_d = 1'b1;
                state_d      = S_DONE;
            end

            S_DONE: begin
                // done is always shown for at least one cycle, even if en already dropped
                if (!done_q) begin
                    done_d = 1'b1;
                end else if (!en) begin
                    done_d       = 1'b0;
                    aggregated_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign address    = address_q;
    assign wr_en      = wr_en_q;
    assign data_out   = data_out_q;
    assign aggregated = aggregated_q;
    assign done       = done_q;

endmodule

// File: tb/tb_agg_collect.sv
// Self-checking bench for agg_collect: registered-read memory model, write
// logger and a behavioural reference computed directly from memory contents.
module tb_agg_collect;

    localparam logic [10:0] A_FLAGS = 11'h001;
    localparam logic [10:0] A_COUNT = 11'h002;
    localparam logic [10:0] A_SUM   = 11'h004;
    localparam logic [10:0] A_MAX   = 11'h005;
    localparam int          A_BUF   = 16;

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic        en    = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic        aggregated;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    agg_collect dut (
        .clock      (clock),
        .nrst       (nrst),
        .en         (en),
        .start      (start),
        .data_in    (data_in),
        .address    (address),
        .wr_en      (wr_en),
        .data_out   (data_out),
        .aggregated (aggregated),
        .done       (done)
    );

    // Memory: data for the address registered at edge k appears on data_in after edge k+1
    logic [15:0] mem [0:2047];
    always @(posedge clock) data_in <= mem[address];

    // Write log, idle data_out watcher and buffer-address tracker
    logic [10:0] wq_addr [$];
    logic [15:0] wq_data [$];
    int          dout_viol;
    bit          seen [32];

    always @(negedge clock) begin
        if (wr_en) begin
            wq_addr.push_back(address);
            wq_data.push_back(data_out);
        end else if (data_out !== 16'h0000) begin
            dout_viol++;
        end
        if (!wr_en && int'(address) >= A_BUF && int'(address) < A_BUF + 32)
            seen[int'(address) - A_BUF] = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        dout_viol = 0;
        foreach (seen[i]) seen[i] = 1'b0;
    endtask

    task automatic reset_dut();
        nrst  = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clock);
        nrst = 1'b1;
    endtask

    task automatic fill_random_buffer();
        for (int i = 0; i < 32; i++)
            mem[A_BUF + i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                                         : 16'($urandom_range(0, 16'h0FFF));
    endtask

    // One full pass, checked against the reference derived from memory contents
    task automatic run_pass(input logic [15:0] flags, input logic [15:0] cnt_word,
                            input bit drop_en, input string name);
        int          n;
        int          exp_lat;
        int          lat;
        int          nreads;
        bit          agg;
        bit          got;
        logic [19:0] sum;
        logic [15:0] mx;
        logic [15:0] exp_sum;
        logic [10:0] exp_a [3];
        logic [15:0] exp_d [3];

        mem[A_FLAGS] = flags;
        mem[A_COUNT] = cnt_word;
        agg = flags[6];
        n   = int'(cnt_word[4:0]);
        if (n > 16) n = 16;
        sum = '0;
        mx  = '0;
        for (int i = 0; i < n; i++) begin
            sum = sum + 20'(mem[A_BUF + i]);
            if (mem[A_BUF + i] > mx) mx = mem[A_BUF + i];
        end
        exp_sum  = (sum > 20'h0FFFF) ? 16'hFFFF : sum[15:0];
        exp_lat  = agg ? (4 + 2 * n + 3 + 1) : 3;
        exp_a[0] = A_SUM;   exp_d[0] = exp_sum;
        exp_a[1] = A_MAX;   exp_d[1] = mx;
        exp_a[2] = A_FLAGS; exp_d[2] = flags & 16'hFFBF;

        clear_log();
        @(negedge clock);
        en    = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;

        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = k;
                got = 1'b1;
                break;
            end
            if (drop_en && k == 2) en = 1'b0;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_aggregated"}, aggregated, agg);

        if (got) begin
            if (drop_en) begin
                @(posedge clock);
                #1;
                chk({name, "_done_pulse"}, done, 1'b0);
                chk({name, "_agg_clear"}, aggregated, 1'b0);
            end else begin
                @(posedge clock);
                #1;
                chk({name, "_done_hold"}, done, 1'b1);
                en = 1'b0;
                @(posedge clock);
                #1;
                chk({name, "_done_clear"}, done, 1'b0);
                chk({name, "_agg_clear"}, aggregated, 1'b0);
            end
        end else begin
            reset_dut();
        end

        chk({name, "_nwrites"}, wq_addr.size(), agg ? 3 : 0);
        if (agg && wq_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s_wr%0d_addr", name, i), wq_addr[i], exp_a[i]);
                chk($sformatf("%s_wr%0d_data", name, i), wq_data[i], exp_d[i]);
            end
        end
        nreads = 0;
        foreach (seen[i]) nreads += int'(seen[i]);
        chk({name, "_buf_reads"}, nreads, agg ? n : 0);
        chk({name, "_dout_idle"}, dout_viol, 0);

        $display("pass %s flags=0x%04h n=%0d sum=0x%05h max=0x%04h lat=%0d writes=%0d",
                 name, flags, n, sum, mx, lat, wq_addr.size());
    endtask

    initial begin
        int rounds;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

        // Reset state while nrst is held low
        nrst = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_address", address, 11'h000);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_done", done, 1'b0);
        chk("rst_aggregated", aggregated, 1'b0);
        nrst = 1'b1;

        // start with en low must be ignored
        clear_log();
        mem[A_FLAGS] = 16'h00C0;
        mem[A_COUNT] = 16'h0002;
        @(negedge clock);
        en    = 1'b0;
        start = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("noen_address", address, 11'h000);
        chk("noen_done", done, 1'b0);
        chk("noen_writes", wq_addr.size(), 0);
        start = 1'b0;
        $display("pass noen start ignored with en=0");

        // Worked example: three members 10, 20, 30
        fill_random_buffer();
        mem[A_BUF + 0] = 16'd10;
        mem[A_BUF + 1] = 16'd20;
        mem[A_BUF + 2] = 16'd30;
        run_pass(16'h00C0, 16'h0003, 1'b0, "ex3");

        // Request bit clear: no writes, short pass
        run_pass(16'h0080, 16'h0005, 1'b0, "noflag");

        // Empty member list
        run_pass(16'h0040, 16'h0000, 1'b0, "empty");

        // Count above the buffer depth, sum saturates
        for (int i = 0; i < 16; i++) mem[A_BUF + i] = 16'h1000;
        for (int i = 16; i < 32; i++) mem[A_BUF + i] = 16'h7777;
        run_pass(16'h00C0, 16'h001F, 1'b0, "clamp");

        // en dropped mid-pass: pass completes, done pulses once
        fill_random_buffer();
        run_pass(16'h0041, 16'h0004, 1'b1, "endrop");
        run_pass(16'h0000, 16'h0004, 1'b1, "endrop_noflag");

        // Randomized passes
        rounds = 14;
        for (int r = 0; r < rounds; r++) begin
            logic [15:0] f;
            logic [15:0] c;
            fill_random_buffer();
            f    = 16'($urandom);
            f[6] = ($urandom_range(0, 3) != 0);
            c    = 16'($urandom);
            run_pass(f, c, ($urandom_range(0, 2) == 0), $sformatf("rnd%0d", r));
        end

        // Reset during the member reads abandons the pass
        fill_random_buffer();
        mem[A_FLAGS] = 16'h0040;
        mem[A_COUNT] = 16'h0008;
        clear_log();
        @(negedge clock);
        en    = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        chk("rstmid_pre_addr", (int'(address) >= A_BUF && int'(address) < A_BUF + 8), 1'b1);
        #2 nrst = 1'b0;
        #1;
        chk("rstmid_address", address, 11'h000);
        chk("rstmid_wr_en", wr_en, 1'b0);
        chk("rstmid_data_out", data_out, 16'h0000);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_aggregated", aggregated, 1'b0);
        en = 1'b0;
        @(negedge clock);
        nrst = 1'b1;
        #1 clear_log();
        repeat (30) @(posedge clock);
        #1;
        chk("rstmid_no_writes", wq_addr.size(), 0);
        chk("rstmid_done_after", done, 1'b0);
        $display("pass rstmid reset during member reads, writes=%0d", wq_addr.size());

        fill_random_buffer();
        run_pass(16'h00C4, 16'h0006, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
